// File: rtl/count_run_sched.sv
// ---------------------------------------------------------------------------
// count_run_sched
//
// Purpose:
//   Round-robin scheduler sharing one CW-bit run counter between two
//   requesters. A requester holds its request high and supplies a run
//   length. The block grants one requester at a time, steps the shared
//   counter through 0 .. len-1 (one value per RUN cycle), then gives the
//   granted requester a one-cycle done pulse. A request that drops while
//   granted ends the run early with a one-cycle abort pulse instead.
//
// Ports:
//   clock1   in   1     rising-edge clock
//   reset    in   1     asynchronous, active-low reset
//   i_req    in   NREQ  level request per requester, held until done/abort
//   i_len0   in   CW    run length for requester 0, sampled in GRANT
//   i_len1   in   CW    run length for requester 1, sampled in GRANT
//   o_gnt    out  NREQ  registered one-hot grant (high in GRANT/RUN/DONE)
//   o_busy   out  1     high whenever a grant is active
//   o_count  out  CW    shared counter value
//   o_done   out  NREQ  one-cycle completion pulse to the granted requester
//   o_abort  out  1     one-cycle pulse when a run ends because req dropped
// ---------------------------------------------------------------------------
module count_run_sched #(
    parameter int CW   = 9,
    parameter int NREQ = 2
) (
    input  logic            clock1,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic [CW-1:0]   i_len0,
    input  logic [CW-1:0]   i_len1,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_busy,
    output logic [CW-1:0]   o_count,
    output logic [NREQ-1:0] o_done,
    output logic            o_abort
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t          r_state;
    state_t          w_nextState;

    logic            r_win;
    logic            r_rrLast;
    logic            r_aborted;
    logic [NREQ-1:0] r_gnt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_lenQ;

    logic            w_anyReq;
    logic            w_winner;
    logic            w_reqHeld;
    logic [CW-1:0]   w_lenW;
    logic            w_lastCount;
    logic            w_abortNow;

    // Arbitration: a lone requester always wins; on a tie the requester
    // that did not finish the previous run wins. r_rrLast resets to 1 so
    // requester 0 takes the very first tie.
    always_comb begin
        w_anyReq = |i_req;
        w_winner = 1'b0;
        if (i_req == 2'b10) begin
            w_winner = 1'b1;
        end else if (i_req == 2'b11) begin
            w_winner = ~r_rrLast;
        end
    end

    // Per-run helpers: whether the granted requester is still asking, the
    // length it presents, and whether the counter sits on its final value.
    // w_lastCount is only consulted in RUN, where r_lenQ is at least 1,
    // so the subtraction cannot underflow there.
    always_comb begin
        w_reqHeld   = i_req[r_win];
        w_lenW      = r_win ? i_len1 : i_len0;
        w_lastCount = (r_count == (r_lenQ - ONE));
        w_abortNow  = ((r_state == GRANT) || (r_state == RUN)) && !w_reqHeld;
    end

    // State register. Reset forces IDLE immediately, even mid-run.
    always_ff @(posedge clock1 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A dropped request takes priority over the normal
    // end of a run, so a drop on the last RUN cycle is reported as abort.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = GRANT;
                end
            end
            GRANT: begin
                if (!w_reqHeld || (w_lenW == '0)) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (!w_reqHeld || w_lastCount) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers: winner and grant latched on leaving IDLE, length
    // captured in GRANT, counter stepping in RUN and freezing on the way
    // into DONE (both for normal completion and abort), cleared when the
    // run is retired. r_aborted remembers why DONE was entered so the DONE
    // cycle can choose between done and abort.
    always_ff @(posedge clock1 or negedge reset) begin
        if (!reset) begin
            r_win     <= 1'b0;
            r_rrLast  <= 1'b1;
            r_aborted <= 1'b0;
            r_gnt     <= '0;
            r_count   <= '0;
            r_lenQ    <= '0;
        end else begin
            r_aborted <= w_abortNow;
            unique case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_anyReq) begin
                        r_win <= w_winner;
                        r_gnt <= {w_winner, ~w_winner};
                    end
                end
                GRANT: begin
                    r_lenQ  <= w_lenW;
                    r_count <= '0;
                end
                RUN: begin
                    if (w_nextState == RUN) begin
                        r_count <= r_count + ONE;
                    end
                end
                DONE: begin
                    r_rrLast <= r_win;
                    r_gnt    <= '0;
                    r_count  <= '0;
                end
                default: begin
                    r_gnt   <= '0;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so nothing here
    // depends combinationally on the inputs.
    always_comb begin
        o_gnt   = r_gnt;
        o_busy  = |r_gnt;
        o_count = r_count;
        o_done  = '0;
        o_abort = 1'b0;
        if (r_state == DONE) begin
            if (r_aborted) begin
                o_abort = 1'b1;
            end else begin
                o_done = r_gnt;
            end
        end
    end

endmodule

// File: tb/tb_count_run_sched.sv
// ---------------------------------------------------------------------------
// tb_count_run_sched
//
// Purpose:
//   Self-checking bench for count_run_sched. A transaction-level model
//   describes each run by its requester, its length and the elapsed cycle
//   since grant; expected outputs are derived from that elapsed time with
//   plain arithmetic. A compare process checks every output on every
//   falling edge. Directed scenarios add literal expectations, then a
//   randomized phase exercises ties, zero lengths and aborts.
// ---------------------------------------------------------------------------
module tb_count_run_sched;

    localparam int CW = 9;

    logic          clock1;
    logic          reset;
    logic [1:0]    i_req;
    logic [CW-1:0] i_len0;
    logic [CW-1:0] i_len1;
    logic [1:0]    o_gnt;
    logic          o_busy;
    logic [CW-1:0] o_count;
    logic [1:0]    o_done;
    logic          o_abort;

    int checks   = 0;
    int failures = 0;

    count_run_sched #(
        .CW   (CW),
        .NREQ (2)
    ) dut (
        .clock1  (clock1),
        .reset   (reset),
        .i_req   (i_req),
        .i_len0  (i_len0),
        .i_len1  (i_len1),
        .o_gnt   (o_gnt),
        .o_busy  (o_busy),
        .o_count (o_count),
        .o_done  (o_done),
        .o_abort (o_abort)
    );

    // 10-unit clock period.
    initial begin
        clock1 = 1'b0;
        forever #5 clock1 = ~clock1;
    end

    // Transaction model: mT counts cycles since grant (0 = grant cycle),
    // mEnd is the cycle on which done/abort is shown.
    bit mBusy;
    int mWho;
    int mLen;
    int mT;
    int mEnd;
    bit mAborted;
    int mLast;

    function automatic int countAt(input int t);
        return (t == 0) ? 0 : t - 1;
    endfunction

    // Model advance: uses the inputs as they stand at the rising edge.
    always @(posedge clock1 or negedge reset) begin
        if (!reset) begin
            mBusy    = 1'b0;
            mWho     = 0;
            mLen     = 0;
            mT       = 0;
            mEnd     = 0;
            mAborted = 1'b0;
            mLast    = 1;
        end else if (!mBusy) begin
            if (i_req != 2'b00) begin
                mBusy    = 1'b1;
                mT       = 0;
                mEnd     = 1 << 30;
                mAborted = 1'b0;
                if (i_req == 2'b11) begin
                    mWho = 1 - mLast;
                end else begin
                    mWho = i_req[1] ? 1 : 0;
                end
            end
        end else if (mT == mEnd) begin
            mLast = mWho;
            mBusy = 1'b0;
        end else begin
            if (mT == 0) begin
                mLen = (mWho == 1) ? int'(i_len1) : int'(i_len0);
                mEnd = mLen + 1;
            end
            if (!i_req[mWho[0]]) begin
                mAborted = 1'b1;
                mEnd     = mT + 1;
            end
            mT++;
        end
    end

    // Every-cycle compare against the model, sampled on the falling edge.
    logic [1:0]    eGnt;
    logic [1:0]    eDone;
    logic [CW-1:0] eCount;
    logic          eAbort;

    always @(negedge clock1) begin
        eGnt   = 2'b00;
        eDone  = 2'b00;
        eCount = '0;
        eAbort = 1'b0;
        if (mBusy) begin
            eGnt = (mWho == 1) ? 2'b10 : 2'b01;
            if (mT < mEnd) begin
                eCount = CW'(countAt(mT));
            end else begin
                eCount = CW'(countAt(mEnd - 1));
                if (mAborted) begin
                    eAbort = 1'b1;
                end else begin
                    eDone = eGnt;
                end
            end
        end
        checks++;
        if (o_gnt !== eGnt || o_busy !== (eGnt != 2'b00) || o_count !== eCount ||
            o_done !== eDone || o_abort !== eAbort) begin
            failures++;
            $display("[TB] FAIL modelCompare t=%0t got gnt=%b busy=%b count=%0d done=%b abort=%b, expected gnt=%b busy=%b count=%0d done=%b abort=%b",
                     $time, o_gnt, o_busy, o_count, o_done, o_abort,
                     eGnt, (eGnt != 2'b00), eCount, eDone, eAbort);
        end
    end

    task automatic applyStimulus(input logic [1:0] req, input logic [CW-1:0] len0,
                                 input logic [CW-1:0] len1);
        i_req  = req;
        i_len0 = len0;
        i_len1 = len1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock1);
        #1;
    endtask

    // Literal comparison of all outputs; busy is expected to follow gnt.
    task automatic checkOutput(input string name, input logic [1:0] expGnt,
                               input int expCount, input logic [1:0] expDone,
                               input logic expAbort);
        checks++;
        if (o_gnt !== expGnt || o_busy !== (expGnt != 2'b00) ||
            o_count !== CW'(expCount) || o_done !== expDone || o_abort !== expAbort) begin
            failures++;
            $display("[TB] FAIL %s got gnt=%b busy=%b count=%0d done=%b abort=%b, expected gnt=%b count=%0d done=%b abort=%b",
                     name, o_gnt, o_busy, o_count, o_done, o_abort,
                     expGnt, expCount, expDone, expAbort);
        end
    endtask

    // Overall time bound so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at t=%0t, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]    r;
        logic [CW-1:0] l0;
        logic [CW-1:0] l1;

        reset = 1'b1;
        applyStimulus(2'b00, '0, '0);
        #2 reset = 1'b0;
        step(2);
        checkOutput("resetState", 2'b00, 0, 2'b00, 1'b0);
        @(negedge clock1) reset = 1'b1;
        step(1);
        checkOutput("idleAfterReset", 2'b00, 0, 2'b00, 1'b0);

        // Single run of length 3 for requester 0.
        $display("[TB] single run len0=3");
        applyStimulus(2'b01, 9'd3, 9'd0);
        step(1); checkOutput("t1 grant", 2'b01, 0, 2'b00, 1'b0);
        step(1); checkOutput("t1 run0",  2'b01, 0, 2'b00, 1'b0);
        step(1); checkOutput("t1 run1",  2'b01, 1, 2'b00, 1'b0);
        step(1); checkOutput("t1 run2",  2'b01, 2, 2'b00, 1'b0);
        step(1); checkOutput("t1 done",  2'b01, 2, 2'b01, 1'b0);
        applyStimulus(2'b00, 9'd3, 9'd0);
        step(1); checkOutput("t1 idle",  2'b00, 0, 2'b00, 1'b0);

        // Zero-length run for requester 1.
        $display("[TB] zero-length run len1=0");
        applyStimulus(2'b10, 9'd0, 9'd0);
        step(1); checkOutput("t3 grant", 2'b10, 0, 2'b00, 1'b0);
        step(1); checkOutput("t3 done",  2'b10, 0, 2'b10, 1'b0);
        applyStimulus(2'b00, 9'd0, 9'd0);
        step(1); checkOutput("t3 idle",  2'b00, 0, 2'b00, 1'b0);

        // Both requesting: alternation r0, r1, r0, r1.
        $display("[TB] round-robin len0=2 len1=4");
        applyStimulus(2'b11, 9'd2, 9'd4);
        for (int e = 1; e <= 23; e++) begin
            step(1);
            case (e)
                1:  checkOutput("t2 grantA", 2'b01, 0, 2'b00, 1'b0);
                4:  checkOutput("t2 doneA",  2'b01, 1, 2'b01, 1'b0);
                5:  checkOutput("t2 gapA",   2'b00, 0, 2'b00, 1'b0);
                6:  checkOutput("t2 grantB", 2'b10, 0, 2'b00, 1'b0);
                11: checkOutput("t2 doneB",  2'b10, 3, 2'b10, 1'b0);
                13: checkOutput("t2 grantC", 2'b01, 0, 2'b00, 1'b0);
                16: checkOutput("t2 doneC",  2'b01, 1, 2'b01, 1'b0);
                18: checkOutput("t2 grantD", 2'b10, 0, 2'b00, 1'b0);
                23: checkOutput("t2 doneD",  2'b10, 3, 2'b10, 1'b0);
                default: ;
            endcase
        end
        applyStimulus(2'b00, 9'd2, 9'd4);
        step(1); checkOutput("t2 idle", 2'b00, 0, 2'b00, 1'b0);

        // Abort: drop the request while count shows 17.
        $display("[TB] abort at count 17");
        applyStimulus(2'b01, 9'd300, 9'd0);
        step(19); checkOutput("t4 count17", 2'b01, 17, 2'b00, 1'b0);
        applyStimulus(2'b00, 9'd300, 9'd0);
        step(1); checkOutput("t4 abort", 2'b01, 17, 2'b00, 1'b1);
        step(1); checkOutput("t4 idle",  2'b00, 0, 2'b00, 1'b0);

        // Asynchronous reset mid-run, then a tie goes to requester 0.
        $display("[TB] reset mid-run");
        applyStimulus(2'b01, 9'd300, 9'd0);
        step(102); checkOutput("t5 count100", 2'b01, 100, 2'b00, 1'b0);
        reset = 1'b0;
        #1 checkOutput("t5 asyncReset", 2'b00, 0, 2'b00, 1'b0);
        applyStimulus(2'b11, 9'd5, 9'd2);
        @(negedge clock1) reset = 1'b1;
        step(1); checkOutput("t5 tieGrantR0", 2'b01, 0, 2'b00, 1'b0);
        applyStimulus(2'b00, 9'd5, 9'd2);
        step(1); checkOutput("t5 abortInGrant", 2'b01, 0, 2'b00, 1'b1);
        step(1); checkOutput("t5 idle", 2'b00, 0, 2'b00, 1'b0);

        // Maximum length: 511 RUN cycles, counter tops out without wrapping.
        $display("[TB] maximum length 511");
        applyStimulus(2'b01, 9'd511, 9'd0);
        step(512); checkOutput("t6 lastRun", 2'b01, 510, 2'b00, 1'b0);
        step(1);   checkOutput("t6 done",    2'b01, 510, 2'b01, 1'b0);
        applyStimulus(2'b00, 9'd511, 9'd0);
        step(1);   checkOutput("t6 idle",    2'b00, 0, 2'b00, 1'b0);

        // Randomized traffic checked by the model every cycle.
        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            r = i_req;
            for (int i = 0; i < 2; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
                end else if (mBusy && mWho == i) begin
                    if (mT == mEnd) begin
                        if ($urandom_range(0, 1) == 0) r[i] = 1'b0;
                    end else if ($urandom_range(0, 39) == 0) begin
                        r[i] = 1'b0;
                    end
                end
            end
            l0 = ($urandom_range(0, 49) == 0) ? CW'($urandom_range(0, 300)) : CW'($urandom_range(0, 12));
            l1 = ($urandom_range(0, 49) == 0) ? CW'($urandom_range(0, 300)) : CW'($urandom_range(0, 12));
            applyStimulus(r, l0, l1);
            step(1);
        end

        applyStimulus(2'b00, '0, '0);
        step(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
